fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 DATA_WIDTH, default 8, SHALL set the bit width of wdata and rdata.
REQ-002 ADDR_WIDTH, default 3, SHALL set DEPTH = 2**ADDR_WIDTH entries; legal range 1..10.
REQ-003 AF_LEVEL, default DEPTH-1, SHALL set the almost_full threshold; legal range 1..DEPTH.
REQ-004 AE_LEVEL, default 1, SHALL set the almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 push  input  1  SHALL be the write request, sampled at the rising edge of clk.
REQ-008 pop  input  1  SHALL be the read request, sampled at the rising edge of clk.
REQ-009 wdata  input  DATA_WIDTH  SHALL be the write data, captured when the push is accepted.
REQ-010 rdata  output  DATA_WIDTH  SHALL present the head entry (show-ahead).
REQ-011 empty  output  1  SHALL be high when count == 0.
REQ-012 full  output  1  SHALL be high when count == DEPTH.
REQ-013 almost_full  output  1  SHALL be high when count >= AF_LEVEL.
REQ-014 almost_empty  output  1  SHALL be high when count <= AE_LEVEL.
REQ-015 count  output  ADDR_WIDTH+1  SHALL give the current occupancy, 0..DEPTH.
REQ-016 overflow  output  1  SHALL be the sticky flag for a rejected push (present only under FIFO_STATUS_EN).
REQ-017 underflow  output  1  SHALL be the sticky flag for a rejected pop (present only under FIFO_STATUS_EN).

Function
REQ-018 Storage SHALL be a DEPTH x DATA_WIDTH register array with ADDR_WIDTH-bit write and read pointers; pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 A push SHALL be accepted when push=1 and (full=0 or pop=1 with full=1); an accepted push SHALL write mem[wptr] and increment wptr.
REQ-020 A pop SHALL be accepted when pop=1 and empty=0; an accepted pop SHALL increment rptr.
REQ-021 rdata SHALL be combinational mem[rptr]; the new head SHALL be visible the cycle after a pop; rdata SHALL be don't-care while empty=1.
REQ-022 Write-to-read latency SHALL be 1 cycle: data pushed at edge N SHALL appear on rdata with empty=0 after edge N.
REQ-023 Simultaneous push and pop while empty SHALL accept the push only; count SHALL become 1.
REQ-024 Simultaneous push and pop while full SHALL accept both; count SHALL stay DEPTH, full SHALL stay high, and the head SHALL be replaced by the next entry.
REQ-025 Simultaneous accepted push and pop at intermediate levels SHALL leave count unchanged.
REQ-026 count SHALL be a registered counter (+1 push only, -1 pop only); all flags SHALL decode from count combinationally.
REQ-027 A push while full without pop, or a pop while empty, SHALL be ignored with no pointer, memory or count change.

Reset
REQ-028 rst=0 SHALL asynchronously clear wptr, rptr and count to 0, giving empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0), and overflow=underflow=0.
REQ-029 Memory contents SHALL NOT be reset; reset asserted mid-transfer SHALL discard all stored entries.
REQ-030 Release of rst SHALL take effect at the next rising edge of clk; push and pop on that edge SHALL be honoured.

Configuration
REQ-031 With macro FIFO_STATUS_EN defined, overflow SHALL set on a rejected push (REQ-027) and underflow SHALL set on a rejected pop; both SHALL hold until rst.
REQ-032 Without FIFO_STATUS_EN, the overflow and underflow ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Defaults: push 8 words 0x10..0x17 -> full=1, count=8 and almost_full from count 7; pop 8 -> rdata 0x10..0x17 in order, then empty=1.
REQ-034 Empty with push+pop and wdata=0xA5 in one cycle -> count=1, rdata=0xA5, no underflow.
REQ-035 Full with push+pop and wdata=0x99 -> count=8, old head popped, 0x99 read out last after the 7 remaining words.
REQ-036 FIFO_STATUS_EN defined: push when full -> overflow=1 sticky, data unchanged; pop when empty -> underflow=1; rst=0 clears both.
REQ-037 Wrap: 20 interleaved push/pop pairs at count=3 -> data in order across pointer wrap, count stays 3.
REQ-038 Assert rst=0 mid-cycle with count=5 -> immediately count=0, empty=1, with no clk edge required.

Source files
------------

// File: rtl/fifo_param_if.sv
// fifo_param_if: push/pop handshake and status bundle for fifo_param.
// The overflow/underflow status pair exists only when FIFO_STATUS_EN is defined.
interface fifo_param_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
);

   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  empty;
   logic                  full;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_STATUS_EN
   logic                  overflow;
   logic                  underflow;
`endif

`ifdef FIFO_STATUS_EN
   // Producer/consumer side: drives requests, observes data and status
   modport master (
      output push, pop, wdata,
      input  rdata, empty, full, almost_full, almost_empty, count, overflow, underflow
   );

   // FIFO side
   modport slave (
      input  push, pop, wdata,
      output rdata, empty, full, almost_full, almost_empty, count, overflow, underflow
   );
`else
   // Producer/consumer side: drives requests, observes data and status
   modport master (
      output push, pop, wdata,
      input  rdata, empty, full, almost_full, almost_empty, count
   );

   // FIFO side
   modport slave (
      input  push, pop, wdata,
      output rdata, empty, full, almost_full, almost_empty, count
   );
`endif

endinterface

// File: rtl/fifo_param.sv
// fifo_param: synchronous show-ahead FIFO, DEPTH = 2**ADDR_WIDTH entries.
// Registered occupancy counter; all flags decode combinationally from it.
// Optional sticky overflow/underflow status under macro FIFO_STATUS_EN.
module fifo_param #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
   parameter int unsigned AE_LEVEL   = 1
) (
   input logic         clk,
   input logic         rst,
   fifo_param_if.slave bus
);

   localparam int unsigned          DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PtrOne   = 1;
   localparam logic [ADDR_WIDTH:0]   CntOne   = 1;
   localparam logic [ADDR_WIDTH:0]   CntDepth = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;

   logic        empty, full, almost_full, almost_empty;
   logic        push_acc, pop_acc;
   int unsigned count_int;

   // Flag decode from the registered occupancy
   always_comb begin
      count_int    = 32'(count_q);
      empty        = (count_q == '0);
      full         = (count_q == CntDepth);
      almost_full  = (count_int >= AF_LEVEL);
      almost_empty = (count_int <= AE_LEVEL);
   end

   // Accept logic: a full FIFO takes a push only when a pop frees the head slot
   always_comb begin
      push_acc = bus.push && (!full || bus.pop);
      pop_acc  = bus.pop && !empty;
   end

   // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_acc) begin
         wptr_d = wptr_q + PtrOne;
      end
      if (pop_acc) begin
         rptr_d = rptr_q + PtrOne;
      end
      if (push_acc && !pop_acc) begin
         count_d = count_q + CntOne;
      end else if (pop_acc && !push_acc) begin
         count_d = count_q - CntOne;
      end
   end

   // Pointer and counter state, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem_q[wptr_q] <= bus.wdata;
      end
   end

`ifdef FIFO_STATUS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error flags; a pop on empty paired with a push is the legal
   // push-only case and is not reported as underflow
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.push && full && !bus.pop) begin
         overflow_d = 1'b1;
      end
      if (bus.pop && empty && !bus.push) begin
         underflow_d = 1'b1;
      end
   end

   // Sticky flag registers, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

   // Show-ahead read port and status outputs
   assign bus.rdata        = mem_q[rptr_q];
   assign bus.empty        = empty;
   assign bus.full         = full;
   assign bus.almost_full  = almost_full;
   assign bus.almost_empty = almost_empty;
   assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param (default parameters).
// Status-flag scenario runs only when FIFO_STATUS_EN is defined.
module tb_fifo_param;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   fifo_param #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(3),
      .AF_LEVEL  (7),
      .AE_LEVEL  (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus; returns 1 time unit after the edge
   task automatic step(input logic p, input logic q, input logic [7:0] d);
      bus.push  = p;
      bus.pop   = q;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
      bus.wdata = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.wdata = 8'h00;
      #2;
      n_cmp++;
      if (bus.count !== 4'd0) begin
         n_err++;
         $display("FAIL reset_count got=%0d exp=0", bus.count);
      end
      n_cmp++;
      if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b1010) begin
         n_err++;
         $display("FAIL reset_flags got=%b exp=1010",
                  {bus.empty, bus.full, bus.almost_empty, bus.almost_full});
      end
`ifdef FIFO_STATUS_EN
      n_cmp++;
      if ({bus.overflow, bus.underflow} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_status got=%b exp=00", {bus.overflow, bus.underflow});
      end
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_fill_drain();
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0, 8'(8'h10 + k - 1));
         n_cmp++;
         if (bus.count !== 4'(k) || bus.almost_full !== (k >= 7) || bus.full !== (k == 8)) begin
            n_err++;
            $display("FAIL fill_%0d got cnt=%0d af=%b f=%b exp cnt=%0d af=%b f=%b", k,
                     bus.count, bus.almost_full, bus.full, k, (k >= 7), (k == 8));
         end
         if (k == 1) begin
            n_cmp++;
            if (bus.rdata !== 8'h10 || bus.empty !== 1'b0) begin
               n_err++;
               $display("FAIL first_latency got rdata=%h empty=%b exp 10/0",
                        bus.rdata, bus.empty);
            end
         end
      end
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (bus.rdata !== 8'(8'h10 + k)) begin
            n_err++;
            $display("FAIL drain_%0d got=%h exp=%h", k, bus.rdata, 8'(8'h10 + k));
         end
         step(1'b0, 1'b1, 8'h00);
      end
      n_cmp++;
      if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin
         n_err++;
         $display("FAIL drain_empty got empty=%b cnt=%0d exp 1/0", bus.empty, bus.count);
      end
   endtask

   task automatic test_empty_push_pop();
      step(1'b1, 1'b1, 8'hA5);
      n_cmp++;
      if (bus.count !== 4'd1 || bus.rdata !== 8'hA5) begin
         n_err++;
         $display("FAIL empty_pp got cnt=%0d rdata=%h exp 1/a5", bus.count, bus.rdata);
      end
`ifdef FIFO_STATUS_EN
      n_cmp++;
      if (bus.underflow !== 1'b0) begin
         n_err++;
         $display("FAIL empty_pp_uflow got=%b exp=0", bus.underflow);
      end
`endif
      step(1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'(8'h20 + k));
      step(1'b1, 1'b1, 8'h99);
      n_cmp++;
      if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.rdata !== 8'h21) begin
         n_err++;
         $display("FAIL full_pp got cnt=%0d full=%b rdata=%h exp 8/1/21",
                  bus.count, bus.full, bus.rdata);
      end
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (bus.rdata !== ((k == 7) ? 8'h99 : 8'(8'h21 + k))) begin
            n_err++;
            $display("FAIL full_pp_drain_%0d got=%h exp=%h", k, bus.rdata,
                     (k == 7) ? 8'h99 : 8'(8'h21 + k));
         end
         step(1'b0, 1'b1, 8'h00);
      end
      n_cmp++;
      if (bus.empty !== 1'b1) begin
         n_err++;
         $display("FAIL full_pp_empty got=%b exp=1", bus.empty);
      end
   endtask

   task automatic test_ignore();
      for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'(8'h30 + k));
      step(1'b1, 1'b0, 8'h55);
      n_cmp++;
      if (bus.count !== 4'd8 || bus.rdata !== 8'h30) begin
         n_err++;
         $display("FAIL push_full got cnt=%0d rdata=%h exp 8/30", bus.count, bus.rdata);
      end
`ifdef FIFO_STATUS_EN
      n_cmp++;
      if (bus.overflow !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_set got=%b exp=1", bus.overflow);
      end
`endif
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (bus.rdata !== 8'(8'h30 + k)) begin
            n_err++;
            $display("FAIL ignore_drain_%0d got=%h exp=%h", k, bus.rdata, 8'(8'h30 + k));
         end
         step(1'b0, 1'b1, 8'h00);
      end
      step(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
         n_err++;
         $display("FAIL pop_empty got cnt=%0d empty=%b exp 0/1", bus.count, bus.empty);
      end
`ifdef FIFO_STATUS_EN
      step(1'b0, 1'b0, 8'h00);
      n_cmp++;
      if ({bus.overflow, bus.underflow} !== 2'b11) begin
         n_err++;
         $display("FAIL status_sticky got=%b exp=11", {bus.overflow, bus.underflow});
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({bus.overflow, bus.underflow} !== 2'b00) begin
         n_err++;
         $display("FAIL status_clear got=%b exp=00", {bus.overflow, bus.underflow});
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
`endif
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'(8'h40 + k));
      for (int k = 0; k < 20; k++) begin
         n_cmp++;
         if (bus.rdata !== 8'(8'h40 + k)) begin
            n_err++;
            $display("FAIL wrap_rd_%0d got=%h exp=%h", k, bus.rdata, 8'(8'h40 + k));
         end
         step(1'b1, 1'b1, 8'(8'h43 + k));
         n_cmp++;
         if (bus.count !== 4'd3) begin
            n_err++;
            $display("FAIL wrap_cnt_%0d got=%0d exp=3", k, bus.count);
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (bus.rdata !== 8'(8'h54 + k)) begin
            n_err++;
            $display("FAIL wrap_tail_%0d got=%h exp=%h", k, bus.rdata, 8'(8'h54 + k));
         end
         step(1'b0, 1'b1, 8'h00);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(8'h60 + k));
      n_cmp++;
      if (bus.count !== 4'd5) begin
         n_err++;
         $display("FAIL mid_pre_cnt got=%0d exp=5", bus.count);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin
         n_err++;
         $display("FAIL mid_reset got cnt=%0d empty=%b ae=%b exp 0/1/1",
                  bus.count, bus.empty, bus.almost_empty);
      end
      @(posedge clk);
      #1;
      // Release with a push pending: the first edge after release honours it
      rst = 1'b1;
      step(1'b1, 1'b0, 8'h77);
      n_cmp++;
      if (bus.count !== 4'd1 || bus.rdata !== 8'h77) begin
         n_err++;
         $display("FAIL post_release got cnt=%0d rdata=%h exp 1/77", bus.count, bus.rdata);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_fill_drain();
      test_empty_push_pop();
      test_full_push_pop();
      test_ignore();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
